// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV64 control path.
// ILLEGAL_TRAP_EN adds the TRAP state used for unsupported opcodes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_SB   = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  // Immediate format implied by the opcode; anything without an immediate gets none.
  function automatic logic [1:0] imm_for(input logic [6:0] opc);
    case (opc)
      OPC_LOAD:   imm_for = IMM_I;
      OPC_STORE:  imm_for = IMM_S;
      OPC_BRANCH: imm_for = IMM_SB;
      default:    imm_for = IMM_NONE;
    endcase
  endfunction

  // True for the opcodes this core executes.
  function automatic logic is_supported(input logic [6:0] opc);
    is_supported = (opc == OPC_LOAD) || (opc == OPC_STORE) ||
                   (opc == OPC_OP)   || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake bundle between the control FSM and the single-port unified memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from opcode and funct fields.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  // R-type picks its op from funct3/funct7; branches compare by subtraction; address math adds.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'b000:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      OPC_BRANCH: alu_ctrl = ALU_SUB;
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV64 core (ld, sd, add/sub/and/or, beq).
// Outputs are decoded from the state register and the IR fields; instret counts retirements.
// Define ILLEGAL_TRAP_EN to trap on unsupported opcodes instead of retiring them as NOPs.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7_5,
  input  logic                    alu_zero,
  multicycle_control_if.master    mem,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic [1:0]              imm_sel,
  output logic                    alu_src_b,
  output logic [3:0]              alu_ctrl,
  output logic                    reg_write,
  output logic                    mem_to_reg,
`ifdef ILLEGAL_TRAP_EN
  output logic                    illegal_insn,
`endif
  output logic [CNT_W-1:0]        instret
);

  state_t     state;
  state_t     next_state;
  logic       retire;
  logic [3:0] dec_alu_ctrl;

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (dec_alu_ctrl)
  );

  // State register; reset forces FETCH so a pending memory request is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Next-state and output decode; everything is held low while reset is asserted.
  always_comb begin
    next_state       = state;
    retire           = 1'b0;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    imm_sel          = 2'b00;
    alu_src_b        = 1'b0;
    alu_ctrl         = 4'b0000;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_insn     = 1'b0;
`endif
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          imm_sel     = IMM_NONE;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
          end
        end
        DECODE: begin
          imm_sel = imm_for(opcode);
          if (is_supported(opcode)) begin
            next_state = EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            next_state = TRAP;
`else
            retire     = 1'b1;
            next_state = FETCH;
`endif
          end
        end
        EXEC: begin
          imm_sel  = imm_for(opcode);
          alu_ctrl = dec_alu_ctrl;
          case (opcode)
            OPC_OP: next_state = WB;
            OPC_LOAD, OPC_STORE: begin
              alu_src_b  = 1'b1;
              next_state = MEM;
            end
            OPC_BRANCH: begin
              if (funct3 == 3'b000 && alu_zero) begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
              end
              retire     = 1'b1;
              next_state = FETCH;
            end
            default: next_state = FETCH;
          endcase
        end
        MEM: begin
          imm_sel          = imm_for(opcode);
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (opcode == OPC_STORE);
          if (mem.mem_ready) begin
            if (opcode == OPC_LOAD) begin
              next_state = WB;
            end else begin
              retire     = 1'b1;
              next_state = FETCH;
            end
          end
        end
        WB: begin
          imm_sel    = imm_for(opcode);
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OPC_LOAD);
          retire     = 1'b1;
          next_state = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          illegal_insn = 1'b1;
          next_state   = TRAP;
        end
`endif
        default: next_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues its expected outputs,
// a negedge monitor pops and compares. Handles both ILLEGAL_TRAP_EN builds.
module tb_multicycle_control;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        asel;
    logic        irw;
    logic        pcw;
    logic        pcs;
    logic [1:0]  imm;
    logic        srcb;
    logic [3:0]  alu;
    logic        rw;
    logic        m2r;
    logic        ill;
    logic [63:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_5 = 1'b0;
  logic        alu_zero = 1'b0;
  logic        ir_write, pc_write, pc_src, alu_src_b, reg_write, mem_to_reg, ill;
  logic [1:0]  imm_sel;
  logic [3:0]  alu_ctrl;
  logic [63:0] instret;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] SD   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;

  multicycle_control_if mem_bus ();

  multicycle_control #(.CNT_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .alu_zero     (alu_zero),
    .mem          (mem_bus.master),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .imm_sel      (imm_sel),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
`ifdef ILLEGAL_TRAP_EN
    .illegal_insn (ill),
`endif
    .instret      (instret)
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  // Free-running core clock.
  always #5 clk = ~clk;

  function automatic exp_t ev(input logic req, we, asel, irw, pcw, pcs,
                              input logic [1:0] imm, input logic srcb,
                              input logic [3:0] alu, input logic rw, m2r, il,
                              input logic [63:0] cnt);
    ev = {req, we, asel, irw, pcw, pcs, imm, srcb, alu, rw, m2r, il, cnt};
  endfunction

  task automatic checkOutput(input string n, input exp_t e);
    exp_t act;
    act = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr_sel, ir_write, pc_write,
           pc_src, imm_sel, alu_src_b, alu_ctrl, reg_write, mem_to_reg, ill, instret};
    total++;
    if (act !== e) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  task automatic applyStimulus(input string n, input logic rn, input logic [6:0] opc,
                               input logic [2:0] f3, input logic f75, input logic z,
                               input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    rst_n             = rn;
    opcode            = opc;
    funct3            = f3;
    funct7_5          = f75;
    alu_zero          = z;
    mem_bus.mem_ready = rdy;
    name_q.push_back(n);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(name_q.pop_front(), exp_q.pop_front());
  end

  initial begin
    mem_bus.mem_ready = 1'b0;
    applyStimulus("rst0", 0, LD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,0,0));
    applyStimulus("rst1", 0, LD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,0,0));
    // ld, zero wait
    applyStimulus("ld_F", 1, LD, 3'b011, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,0));
    applyStimulus("ld_D", 1, LD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,0,0));
    applyStimulus("ld_E", 1, LD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,1,4'b0010,0,0,0,0));
    applyStimulus("ld_M", 1, LD, 3'b011, 0, 0, 1, ev(1,0,1,0,0,0,2'b00,0,4'b0000,0,0,0,0));
    applyStimulus("ld_W", 1, LD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,1,1,0,0));
    // sd, three memory wait cycles
    applyStimulus("sd_F", 1, SD, 3'b011, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,1));
    applyStimulus("sd_D", 1, SD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b01,0,4'b0000,0,0,0,1));
    applyStimulus("sd_E", 1, SD, 3'b011, 0, 0, 0, ev(0,0,0,0,0,0,2'b01,1,4'b0010,0,0,0,1));
    for (int i = 0; i < 3; i++)
      applyStimulus("sd_Mwait", 1, SD, 3'b011, 0, 0, 0, ev(1,1,1,0,0,0,2'b01,0,4'b0000,0,0,0,1));
    applyStimulus("sd_Mrdy", 1, SD, 3'b011, 0, 0, 1, ev(1,1,1,0,0,0,2'b01,0,4'b0000,0,0,0,1));
    // beq taken
    applyStimulus("beqT_F", 1, BR, 3'b000, 0, 1, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,2));
    applyStimulus("beqT_D", 1, BR, 3'b000, 0, 1, 1, ev(0,0,0,0,0,0,2'b10,0,4'b0000,0,0,0,2));
    applyStimulus("beqT_E", 1, BR, 3'b000, 0, 1, 1, ev(0,0,0,0,1,1,2'b10,0,4'b0110,0,0,0,2));
    // beq not taken
    applyStimulus("beqN_F", 1, BR, 3'b000, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,3));
    applyStimulus("beqN_D", 1, BR, 3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b10,0,4'b0000,0,0,0,3));
    applyStimulus("beqN_E", 1, BR, 3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b10,0,4'b0110,0,0,0,3));
    // branch with funct3 != 000 never taken
    applyStimulus("bne_F", 1, BR, 3'b001, 0, 1, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,4));
    applyStimulus("bne_D", 1, BR, 3'b001, 0, 1, 1, ev(0,0,0,0,0,0,2'b10,0,4'b0000,0,0,0,4));
    applyStimulus("bne_E", 1, BR, 3'b001, 0, 1, 1, ev(0,0,0,0,0,0,2'b10,0,4'b0110,0,0,0,4));
    // sub with one fetch wait
    applyStimulus("sub_Fw", 1, OPR, 3'b000, 1, 0, 0, ev(1,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,5));
    applyStimulus("sub_F",  1, OPR, 3'b000, 1, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,5));
    applyStimulus("sub_D",  1, OPR, 3'b000, 1, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,5));
    applyStimulus("sub_E",  1, OPR, 3'b000, 1, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0110,0,0,0,5));
    applyStimulus("sub_W",  1, OPR, 3'b000, 1, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,1,0,0,5));
    // or, and, add
    applyStimulus("or_F",  1, OPR, 3'b110, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,6));
    applyStimulus("or_D",  1, OPR, 3'b110, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,6));
    applyStimulus("or_E",  1, OPR, 3'b110, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0001,0,0,0,6));
    applyStimulus("or_W",  1, OPR, 3'b110, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,1,0,0,6));
    applyStimulus("and_F", 1, OPR, 3'b111, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,7));
    applyStimulus("and_D", 1, OPR, 3'b111, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,7));
    applyStimulus("and_E", 1, OPR, 3'b111, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,7));
    applyStimulus("and_W", 1, OPR, 3'b111, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,1,0,0,7));
    applyStimulus("add_F", 1, OPR, 3'b000, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,8));
    applyStimulus("add_D", 1, OPR, 3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,8));
    applyStimulus("add_E", 1, OPR, 3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0010,0,0,0,8));
    applyStimulus("add_W", 1, OPR, 3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b11,0,4'b0000,1,0,0,8));
    // ld interrupted by reset while waiting in MEM
    applyStimulus("ldR_F", 1, LD, 3'b011, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,9));
    applyStimulus("ldR_D", 1, LD, 3'b011, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,0,9));
    applyStimulus("ldR_E", 1, LD, 3'b011, 0, 0, 0, ev(0,0,0,0,0,0,2'b00,1,4'b0010,0,0,0,9));
    applyStimulus("ldR_M", 1, LD, 3'b011, 0, 0, 0, ev(1,0,1,0,0,0,2'b00,0,4'b0000,0,0,0,9));
    applyStimulus("midrst", 0, LD, 3'b011, 0, 0, 0, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,0,0));
    applyStimulus("midrst2", 0, LD, 3'b011, 0, 0, 0, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,0,0));
    applyStimulus("rel_F", 1, ADDI, 3'b000, 0, 0, 0, ev(1,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,0));
    // unsupported opcode
    applyStimulus("ill_F", 1, ADDI, 3'b000, 0, 0, 1, ev(1,0,0,1,1,0,2'b11,0,4'b0000,0,0,0,0));
    applyStimulus("ill_D", 1, ADDI, 3'b000, 0, 0, 0, ev(0,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,0));
`ifdef ILLEGAL_TRAP_EN
    applyStimulus("trap0", 1, ADDI, 3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,1,0));
    applyStimulus("trap1", 1, LD,   3'b000, 0, 0, 1, ev(0,0,0,0,0,0,2'b00,0,4'b0000,0,0,1,0));
`else
    applyStimulus("nop_F", 1, ADDI, 3'b000, 0, 0, 0, ev(1,0,0,0,0,0,2'b11,0,4'b0000,0,0,0,1));
`endif
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
